// File: rtl/ra_march_pkg.sv
// ra_march_pkg: shared state encoding, background selects and pattern
// constants for the March C- BIST sequencer and its checker.
package ra_march_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_M0,
        ST_M1,
        ST_M2,
        ST_M3,
        ST_M4,
        ST_M5,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [1:0] BG_SEL_ZEROS  = 2'b00;
    localparam logic [1:0] BG_SEL_FIVES  = 2'b01;
    localparam logic [1:0] BG_SEL_THREES = 2'b10;
    localparam logic [1:0] BG_SEL_ADDR   = 2'b11;

    localparam int              BG_W      = 72;
    localparam logic [BG_W-1:0] BG_ZEROS  = '0;
    localparam logic [BG_W-1:0] BG_FIVES  = {9{8'h55}};
    localparam logic [BG_W-1:0] BG_THREES = {9{8'h33}};

    localparam logic [7:0] FAIL_CNT_MAX = 8'hFF;

    // Up elements sweep address 0 to max; down elements sweep max to 0.
    function automatic logic elem_is_up(state_t s);
        return (s == ST_M0) || (s == ST_M1) || (s == ST_M2) || (s == ST_M5);
    endfunction

    // Elements whose read expects the inverted background (D1).
    function automatic logic elem_reads_inv(state_t s);
        return (s == ST_M2) || (s == ST_M4);
    endfunction

endpackage

// File: rtl/ra_march_chk.sv
// ra_march_chk: delays expected data and address by the array read latency,
// compares against returned read data and keeps the sticky fail summary.
module ra_march_chk #(
    parameter int AW     = 6,
    parameter int DW     = 72,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          rd_vld,
    input  logic [AW-1:0] rd_adr,
    input  logic [DW-1:0] rd_exp,
    input  logic [DW-1:0] rd_dat,
    output logic          fail,
    output logic [AW-1:0] fail_adr,
    output logic [7:0]    fail_cnt
);
    import ra_march_pkg::*;

    localparam int LAST = RD_LAT - 1;

    logic          pv_q [RD_LAT];
    logic          pv_d [RD_LAT];
    logic [AW-1:0] pa_q [RD_LAT];
    logic [AW-1:0] pa_d [RD_LAT];
    logic [DW-1:0] pe_q [RD_LAT];
    logic [DW-1:0] pe_d [RD_LAT];

    logic          fail_q, fail_d;
    logic [AW-1:0] fail_adr_q, fail_adr_d;
    logic [7:0]    fail_cnt_q, fail_cnt_d;
    logic          mismatch;

    // Shift the read tag (valid, address, expected word) one stage per cycle.
    always_comb begin
        pv_d[0] = rd_vld;
        pa_d[0] = rd_adr;
        pe_d[0] = rd_exp;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pa_d[i] = pa_q[i-1];
            pe_d[i] = pe_q[i-1];
        end
    end

    // Pipe registers line up with the array's read data at the last stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pv_q[i] <= 1'b0;
                pa_q[i] <= '0;
                pe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                pv_q[i] <= pv_d[i];
                pa_q[i] <= pa_d[i];
                pe_q[i] <= pe_d[i];
            end
        end
    end

    assign mismatch = pv_q[LAST] && (pe_q[LAST] != rd_dat);

    // Fail summary: a new run clears it; a miscompare sets the sticky flag,
    // captures the first failing address and bumps the saturating count.
    always_comb begin
        fail_d     = fail_q;
        fail_adr_d = fail_adr_q;
        fail_cnt_d = fail_cnt_q;
        if (clr) begin
            fail_d     = 1'b0;
            fail_adr_d = '0;
            fail_cnt_d = '0;
        end else if (mismatch) begin
            fail_d = 1'b1;
            if (!fail_q) begin
                fail_adr_d = pa_q[LAST];
            end
            if (fail_cnt_q != FAIL_CNT_MAX) begin
                fail_cnt_d = fail_cnt_q + 8'd1;
            end
        end
    end

    // Fail summary registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_q     <= 1'b0;
            fail_adr_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            fail_q     <= fail_d;
            fail_adr_q <= fail_adr_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign fail     = fail_q;
    assign fail_adr = fail_adr_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: rtl/ra_march_sdr.sv
// ra_march_sdr: March C- sequencer for the 2R1W SDR test array. Issues one
// array operation per cycle through registered read/write ports and hands
// each read's expected word to ra_march_chk for comparison.
module ra_march_sdr #(
    parameter int AW     = 6,
    parameter int DW     = 72,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    bg_sel,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [AW-1:0] fail_adr,
    output logic [7:0]    fail_cnt,
    output logic          rd_enb,
    output logic [AW-1:0] rd_adr,
    output logic          wr_enb,
    output logic [AW-1:0] wr_adr,
    output logic [DW-1:0] wr_dat,
    input  logic [DW-1:0] rd_dat
);
    import ra_march_pkg::*;

    localparam int             DCW        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(RD_LAT - 1);

    state_t         state_q, state_d;
    logic [AW-1:0]  adr_q, adr_d;
    logic           phase_q, phase_d;
    logic [1:0]     bg_q, bg_d;
    logic [DCW-1:0] drain_q, drain_d;

    logic           rd_enb_q, rd_enb_d;
    logic [AW-1:0]  rd_adr_q, rd_adr_d;
    logic [DW-1:0]  exp_q, exp_d;
    logic           wr_enb_q, wr_enb_d;
    logic [AW-1:0]  wr_adr_q, wr_adr_d;
    logic [DW-1:0]  wr_dat_q, wr_dat_d;

    logic           clr;
    logic           elem_up;
    logic           elem_end;
    logic [AW-1:0]  adr_step;
    state_t         next_elem;
    logic [DW-1:0]  d0;
    logic [DW-1:0]  d1;

    // Background word D0 for the current address; the address mode repeats
    // the address across the word so every location holds unique data.
    function automatic logic [DW-1:0] d0_word(logic [1:0] sel, logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < DW; i++) begin
            case (sel)
                BG_SEL_ZEROS:  w[i] = BG_ZEROS[i % BG_W];
                BG_SEL_FIVES:  w[i] = BG_FIVES[i % BG_W];
                BG_SEL_THREES: w[i] = BG_THREES[i % BG_W];
                default:       w[i] = a[i % AW];
            endcase
        end
        return w;
    endfunction

    assign d0        = d0_word(bg_q, adr_q);
    assign d1        = ~d0;
    assign elem_up   = elem_is_up(state_q);
    assign elem_end  = elem_up ? (adr_q == '1) : (adr_q == '0);
    assign adr_step  = elem_up ? (adr_q + AW'(1)) : (adr_q - AW'(1));
    assign next_elem = state_t'(state_q + 4'd1);

    // Sequencer: element/address/phase stepping and next array operation.
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        phase_d  = phase_q;
        bg_d     = bg_q;
        drain_d  = drain_q;
        rd_enb_d = 1'b0;
        rd_adr_d = '0;
        exp_d    = '0;
        wr_enb_d = 1'b0;
        wr_adr_d = '0;
        wr_dat_d = '0;
        clr      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_M0;
                    bg_d    = bg_sel;
                    adr_d   = '0;
                    phase_d = 1'b0;
                    clr     = 1'b1;
                end
            end
            ST_M0: begin
                wr_enb_d = 1'b1;
                wr_adr_d = adr_q;
                wr_dat_d = d0;
                if (elem_end) begin
                    state_d = ST_M1;
                    adr_d   = '0;
                end else begin
                    adr_d = adr_step;
                end
            end
            ST_M1, ST_M2, ST_M3, ST_M4: begin
                if (!phase_q) begin
                    rd_enb_d = 1'b1;
                    rd_adr_d = adr_q;
                    exp_d    = elem_reads_inv(state_q) ? d1 : d0;
                    phase_d  = 1'b1;
                end else begin
                    wr_enb_d = 1'b1;
                    wr_adr_d = adr_q;
                    wr_dat_d = elem_reads_inv(state_q) ? d0 : d1;
                    phase_d  = 1'b0;
                    if (elem_end) begin
                        state_d = next_elem;
                        adr_d   = elem_is_up(next_elem) ? '0 : '1;
                    end else begin
                        adr_d = adr_step;
                    end
                end
            end
            ST_M5: begin
                rd_enb_d = 1'b1;
                rd_adr_d = adr_q;
                exp_d    = d0;
                if (elem_end) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    adr_d = adr_step;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered array port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            adr_q    <= '0;
            phase_q  <= 1'b0;
            bg_q     <= '0;
            drain_q  <= '0;
            rd_enb_q <= 1'b0;
            rd_adr_q <= '0;
            exp_q    <= '0;
            wr_enb_q <= 1'b0;
            wr_adr_q <= '0;
            wr_dat_q <= '0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            phase_q  <= phase_d;
            bg_q     <= bg_d;
            drain_q  <= drain_d;
            rd_enb_q <= rd_enb_d;
            rd_adr_q <= rd_adr_d;
            exp_q    <= exp_d;
            wr_enb_q <= wr_enb_d;
            wr_adr_q <= wr_adr_d;
            wr_dat_q <= wr_dat_d;
        end
    end

    assign busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done   = (state_q == ST_DONE);
    assign rd_enb = rd_enb_q;
    assign rd_adr = rd_adr_q;
    assign wr_enb = wr_enb_q;
    assign wr_adr = wr_adr_q;
    assign wr_dat = wr_dat_q;

    // Expected word travels with the registered read enable so the checker
    // sees the same timing as the array's read port.
    ra_march_chk #(
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_chk (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .rd_vld   (rd_enb_q),
        .rd_adr   (rd_adr_q),
        .rd_exp   (exp_q),
        .rd_dat   (rd_dat),
        .fail     (fail),
        .fail_adr (fail_adr),
        .fail_cnt (fail_cnt)
    );

endmodule
